// File: rtl/cond_unit_pkg.sv
// Shared processor definitions: condition-code encodings and flag bit positions.
// Imported by the decoder and by the condition unit.
package cond_unit_pkg;

  localparam logic [2:0] COND_EQ     = 3'b000;
  localparam logic [2:0] COND_NE     = 3'b001;
  localparam logic [2:0] COND_LT     = 3'b010;
  localparam logic [2:0] COND_LE     = 3'b011;
  localparam logic [2:0] COND_CO     = 3'b100;
  localparam logic [2:0] COND_NC     = 3'b101;
  localparam logic [2:0] COND_LTU    = 3'b110;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  // Flags are packed as {Z,C,N,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  function automatic flags_t pack_flags(input logic z, input logic c,
                                        input logic n, input logic v);
    flags_t f;
    f         = 4'b0000;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/cond_unit_eval.sv
// Combinational condition evaluator: selects one predicate of the {Z,C,N,V} flags.
module cond_eval
  import cond_unit_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       result
);

  logic z_s, c_s, n_s, v_s;
  logic result_s;

  assign z_s = flags[FLAG_Z];
  assign c_s = flags[FLAG_C];
  assign n_s = flags[FLAG_N];
  assign v_s = flags[FLAG_V];

  // Condition-code decode
  always_comb begin
    result_s = 1'b0;
    case (cond)
      COND_EQ:     result_s = z_s;
      COND_NE:     result_s = ~z_s;
      COND_LT:     result_s = n_s ^ v_s;
      COND_LE:     result_s = z_s | (n_s ^ v_s);
      COND_CO:     result_s = c_s;
      COND_NC:     result_s = ~c_s;
      COND_LTU:    result_s = ~c_s;
      COND_ALWAYS: result_s = 1'b1;
      default:     result_s = 1'b0;
    endcase
  end

  assign result = result_s;

endmodule

// File: rtl/cond_unit.sv
// Condition unit: flag register, condition evaluation and an optional
// valid/ready output register producing a zero-extended set result.
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit BYPASS  = 1'b1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_ovf,
  input  logic             eval_valid,
  input  logic [2:0]       cond,
  output logic             eval_ready,
  output logic             set_valid,
  output logic [WIDTH-1:0] set_out,
  input  logic             set_ready,
  output logic [3:0]       flags
);

  flags_t           flags_r;
  flags_t           new_flags_s;
  flags_t           src_flags_s;
  logic             result_s;
  logic [WIDTH-1:0] result_ext_s;

  assign new_flags_s = pack_flags(alu_out == {WIDTH{1'b0}}, alu_cout,
                                  alu_out[WIDTH-1], alu_ovf);

  // Flag source: freshly derived flags forward into a same-cycle evaluation
  always_comb begin
    src_flags_s = flags_r;
    if (BYPASS && flag_we) begin
      src_flags_s = new_flags_s;
    end else begin
      src_flags_s = flags_r;
    end
  end

  cond_eval u_cond_eval (
    .flags  (src_flags_s),
    .cond   (cond),
    .result (result_s)
  );

  assign result_ext_s = {{(WIDTH-1){1'b0}}, result_s};

  // Flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else if (flag_we) begin
      flags_r <= new_flags_s;
    end else begin
      flags_r <= flags_r;
    end
  end

  assign flags = flags_r;

  generate
    if (OUT_REG) begin : g_out_reg
      logic             set_valid_r;
      logic [WIDTH-1:0] set_out_r;
      logic             accept_s;

      assign eval_ready = ~set_valid_r | set_ready;
      assign accept_s   = eval_valid & eval_ready;

      // Output stage: a new acceptance overwrites, a lone set_ready drains
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          set_valid_r <= 1'b0;
          set_out_r   <= {WIDTH{1'b0}};
        end else if (accept_s) begin
          set_valid_r <= 1'b1;
          set_out_r   <= result_ext_s;
        end else if (set_ready) begin
          set_valid_r <= 1'b0;
          set_out_r   <= set_out_r;
        end else begin
          set_valid_r <= set_valid_r;
          set_out_r   <= set_out_r;
        end
      end

      assign set_valid = set_valid_r;
      assign set_out   = set_out_r;
    end else begin : g_out_comb
      logic unused_set_ready_s;

      // Pass-through mode never stalls, so set_ready has no effect
      assign unused_set_ready_s = set_ready;
      assign eval_ready         = 1'b1;
      assign set_valid          = eval_valid;
      assign set_out            = result_ext_s;
    end
  endgenerate

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (several parameterisations) and cond_eval.
module tb_cond_unit;
  import cond_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flag_we;
  logic [31:0] alu32;
  logic [15:0] alu16;
  logic        alu_cout;
  logic        alu_ovf;
  logic        eval_valid;
  logic [2:0]  cond;
  logic        set_ready;

  logic        er_a, sv_a, er_b, sv_b, er_w, sv_w, er_c, sv_c;
  logic [15:0] so_a, so_b, so_c;
  logic [31:0] so_w;
  logic [3:0]  fl_a, fl_b, fl_w, fl_c;

  logic [3:0]  ce_flags;
  logic [2:0]  ce_cond;
  logic        ce_res;

  int errors = 0;
  int checks = 0;

  assign alu16 = alu32[15:0];

  cond_unit #(.WIDTH(16), .BYPASS(1'b1), .OUT_REG(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_out(alu16), .alu_cout(alu_cout),
    .alu_ovf(alu_ovf), .eval_valid(eval_valid), .cond(cond), .eval_ready(er_a),
    .set_valid(sv_a), .set_out(so_a), .set_ready(set_ready), .flags(fl_a));

  cond_unit #(.WIDTH(16), .BYPASS(1'b0), .OUT_REG(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_out(alu16), .alu_cout(alu_cout),
    .alu_ovf(alu_ovf), .eval_valid(eval_valid), .cond(cond), .eval_ready(er_b),
    .set_valid(sv_b), .set_out(so_b), .set_ready(set_ready), .flags(fl_b));

  cond_unit #(.WIDTH(32), .BYPASS(1'b1), .OUT_REG(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_out(alu32), .alu_cout(alu_cout),
    .alu_ovf(alu_ovf), .eval_valid(eval_valid), .cond(cond), .eval_ready(er_w),
    .set_valid(sv_w), .set_out(so_w), .set_ready(set_ready), .flags(fl_w));

  cond_unit #(.WIDTH(16), .BYPASS(1'b1), .OUT_REG(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_out(alu16), .alu_cout(alu_cout),
    .alu_ovf(alu_ovf), .eval_valid(eval_valid), .cond(cond), .eval_ready(er_c),
    .set_valid(sv_c), .set_out(so_c), .set_ready(set_ready), .flags(fl_c));

  cond_eval u_ce (.flags(ce_flags), .cond(ce_cond), .result(ce_res));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference truth table for the condition codes, flags packed {Z,C,N,V}
  function automatic logic ref_cond(input logic [3:0] f, input logic [2:0] c);
    logic z, cy, n, v;
    z = f[3]; cy = f[2]; n = f[1]; v = f[0];
    case (c)
      3'd0:    return z;
      3'd1:    return !z;
      3'd2:    return n != v;
      3'd3:    return z || (n != v);
      3'd4:    return cy;
      3'd5:    return !cy;
      3'd6:    return !cy;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset();
    #2;
    checks++; if (fl_a !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", fl_a); end
    checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL reset_set_valid: got %b expected 0", sv_a); end
    checks++; if (so_a !== 16'h0000) begin errors++; $display("FAIL reset_set_out: got %h expected 0000", so_a); end
    checks++; if (er_a !== 1'b1) begin errors++; $display("FAIL reset_eval_ready: got %b expected 1", er_a); end
    #6 rst_n = 1'b1;
  endtask

  task automatic test_flag_load();
    flag_we = 1'b1; alu32 = 32'h0000_8000; alu_cout = 1'b0; alu_ovf = 1'b0;
    eval_valid = 1'b0; set_ready = 1'b1;
    step();
    checks++; if (fl_a !== 4'b0010) begin errors++; $display("FAIL load_flags: got %b expected 0010", fl_a); end
    flag_we = 1'b0; eval_valid = 1'b1; cond = COND_LT;
    #1;
    checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL load_latency: got set_valid %b expected 0", sv_a); end
    step();
    checks++; if (sv_a !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", sv_a); end
    checks++; if (so_a !== 16'h0001) begin errors++; $display("FAIL load_lt: got %h expected 0001", so_a); end
    eval_valid = 1'b0;
    step();
    checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL load_drain: got %b expected 0", sv_a); end
  endtask

  task automatic test_bypass();
    flag_we = 1'b1; alu32 = 32'h0000_0001; eval_valid = 1'b0;
    step();
    alu32 = 32'h0; eval_valid = 1'b1; cond = COND_EQ;
    step();
    checks++; if (so_a !== 16'h0001) begin errors++; $display("FAIL bypass_on: got %h expected 0001", so_a); end
    checks++; if (so_b !== 16'h0000) begin errors++; $display("FAIL bypass_off: got %h expected 0000", so_b); end
    checks++; if (fl_b !== 4'b1000) begin errors++; $display("FAIL bypass_flags: got %b expected 1000", fl_b); end
    flag_we = 1'b0; eval_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  cs [3];
    logic [15:0] ex [3];
    cs[0] = COND_NE; cs[1] = COND_LE; cs[2] = COND_CO;
    ex[0] = 16'h0000; ex[1] = 16'h0001; ex[2] = 16'h0000;
    set_ready = 1'b0; eval_valid = 1'b1; cond = COND_EQ;
    step();
    cond = COND_NE;
    for (int i = 0; i < 3; i++) begin
      checks++; if (er_a !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, er_a); end
      step();
      checks++; if (so_a !== 16'h0001 || sv_a !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%b expected 0001/1", i, so_a, sv_a); end
    end
    set_ready = 1'b1;
    #1;
    checks++; if (er_a !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", er_a); end
    for (int i = 0; i < 3; i++) begin
      cond = cs[i];
      step();
      checks++; if (so_a !== ex[i] || sv_a !== 1'b1) begin errors++; $display("FAIL b2b[%0d]: got %h/%b expected %h/1", i, so_a, sv_a, ex[i]); end
    end
    eval_valid = 1'b0;
    step();
    checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", sv_a); end
  endtask

  task automatic test_stall_reset();
    set_ready = 1'b0; eval_valid = 1'b1; cond = COND_EQ;
    step();
    eval_valid = 1'b0; flag_we = 1'b1; alu32 = 32'h0000_8000; alu_cout = 1'b1;
    step();
    flag_we = 1'b0;
    checks++; if (so_a !== 16'h0001 || sv_a !== 1'b1) begin errors++; $display("FAIL stall_flag_we: got %h/%b expected 0001/1", so_a, sv_a); end
    checks++; if (fl_a !== 4'b0110) begin errors++; $display("FAIL stall_flags: got %b expected 0110", fl_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (sv_a !== 1'b0 || so_a !== 16'h0000) begin errors++; $display("FAIL async_reset_out: got %h/%b expected 0000/0", so_a, sv_a); end
    checks++; if (fl_a !== 4'b0000) begin errors++; $display("FAIL async_reset_flags: got %b expected 0000", fl_a); end
    checks++; if (er_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", er_a); end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (sv_a !== 1'b0) begin errors++; $display("FAIL post_reset_valid[%0d]: got %b expected 0", i, sv_a); end
    end
    set_ready = 1'b1; alu_cout = 1'b0;
  endtask

  task automatic test_width32();
    flag_we = 1'b1; alu32 = 32'hFFFF_FFFF; alu_cout = 1'b0; alu_ovf = 1'b1;
    eval_valid = 1'b1; cond = COND_LE; set_ready = 1'b1;
    step();
    checks++; if (so_w !== 32'h0000_0000 || sv_w !== 1'b1) begin errors++; $display("FAIL w32_le: got %h/%b expected 00000000/1", so_w, sv_w); end
    checks++; if (fl_w !== 4'b0011) begin errors++; $display("FAIL w32_flags: got %b expected 0011", fl_w); end
    flag_we = 1'b0; cond = COND_ALWAYS;
    step();
    checks++; if (so_w !== 32'h0000_0001) begin errors++; $display("FAIL w32_always: got %h expected 00000001", so_w); end
    eval_valid = 1'b0; alu_ovf = 1'b0;
    step();
  endtask

  task automatic test_exhaustive();
    logic [3:0] fv;
    logic [2:0] cv;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 8; c++) begin
        fv = f[3:0]; cv = c[2:0];
        ce_flags = fv; ce_cond = cv;
        #1;
        checks++; if (ce_res !== ref_cond(fv, cv)) begin errors++; $display("FAIL eval f=%b c=%0d: got %b expected %b", fv, c, ce_res, ref_cond(fv, cv)); end
      end
    end
    // Through the pass-through top: every flag pattern the ALU inputs can produce
    for (int f = 0; f < 16; f++) begin
      fv = f[3:0];
      if (!(fv[3] && fv[1])) begin
        alu32 = fv[3] ? 32'h0 : (fv[1] ? 32'h0000_8000 : 32'h0000_0001);
        alu_cout = fv[2]; alu_ovf = fv[0]; flag_we = 1'b1; eval_valid = 1'b0;
        step();
        flag_we = 1'b0;
        checks++; if (fl_c !== fv) begin errors++; $display("FAIL comb_flags: got %b expected %b", fl_c, fv); end
        checks++; if (sv_c !== 1'b0) begin errors++; $display("FAIL comb_idle_valid: got %b expected 0", sv_c); end
        eval_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
          cv = c[2:0]; cond = cv;
          #1;
          checks++; if (so_c !== {15'd0, ref_cond(fv, cv)} || sv_c !== 1'b1 || er_c !== 1'b1)
            begin errors++; $display("FAIL comb f=%b c=%0d: got %h/%b/%b expected %h/1/1", fv, c, so_c, sv_c, er_c, {15'd0, ref_cond(fv, cv)}); end
        end
        eval_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flag_we = 1'b0; alu32 = 32'h0; alu_cout = 1'b0; alu_ovf = 1'b0;
    eval_valid = 1'b0; cond = 3'd0; set_ready = 1'b1; ce_flags = 4'd0; ce_cond = 3'd0;
    test_reset();
    test_flag_load();
    test_bypass();
    test_back_to_back();
    test_stall_reset();
    test_width32();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
